// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU operation codes,
// operand-select encodings, the immediate-format enum, the decoded-entry
// record and the immediate builder used by the decoder.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // AluOp = {m_unit, instr[30], funct3}
    localparam logic [4:0] ALU_ADD = 5'b00000;

    typedef enum logic [1:0] {
        LHS_RS1  = 2'd0,
        LHS_PC   = 2'd1,
        LHS_ZERO = 2'd2
    } lhs_sel_e;

    typedef enum logic [1:0] {
        RHS_RS2 = 2'd0,
        RHS_IMM = 2'd1
    } rhs_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        lhs_sel_e    lhs_sel;
        rhs_sel_e    rhs_sel;
        logic [4:0]  alu_op;
        logic        writes_rf;
        logic        reads_ram;
        logic        writes_ram;
        logic        branch;
        logic        jump;
        logic [2:0]  mem_funct;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] build_imm(input imm_fmt_e fmt, input logic [31:0] i);
        case (fmt)
            IMM_I:   build_imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   build_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   build_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   build_imm = {i[31:12], 12'b0};
            IMM_J:   build_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: build_imm = '0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
//   slave  : the decode stage (consumes InValid/Instruction/Pc/OutReady,
//            produces InReady and the decoded entry)
//   master : the surrounding fetch/execute environment
interface rv32_decode_stage_if #(
    parameter int ICOUNT_W = 16
);
    logic                InValid;
    logic                InReady;
    logic [31:0]         Instruction;
    logic [31:0]         Pc;
    logic                OutValid;
    logic                OutReady;
    logic [31:0]         OutPc;
    logic [4:0]          RD;
    logic [4:0]          RS1;
    logic [4:0]          RS2;
    logic [31:0]         Imm;
    logic [1:0]          LhsSel;
    logic [1:0]          RhsSel;
    logic [4:0]          AluOp;
    logic                WritesRegisterFile;
    logic                ReadsRam;
    logic                WritesRam;
    logic                Branch;
    logic                Jump;
    logic [2:0]          MemFunct;
    logic                Illegal;
    logic [ICOUNT_W-1:0] IllegalCount;

    modport slave (
        input  InValid, Instruction, Pc, OutReady,
        output InReady, OutValid, OutPc, RD, RS1, RS2, Imm, LhsSel, RhsSel, AluOp,
               WritesRegisterFile, ReadsRam, WritesRam, Branch, Jump, MemFunct,
               Illegal, IllegalCount
    );

    modport master (
        output InValid, Instruction, Pc, OutReady,
        input  InReady, OutValid, OutPc, RD, RS1, RS2, Imm, LhsSel, RhsSel, AluOp,
               WritesRegisterFile, ReadsRam, WritesRam, Branch, Jump, MemFunct,
               Illegal, IllegalCount
    );
endinterface

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I (+ optional M) instruction decoder.
//   instr : raw 32-bit instruction word
//   dec   : decoded entry; illegal words have all control strobes cleared
module rv32_decode_comb
    import rv32_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    imm_fmt_e   fmt;
    logic       legal;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        dec       = '0;
        fmt       = IMM_NONE;
        legal     = 1'b1;
        dec.rd    = instr[11:7];
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];

        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (instr[6:0])
                OPC_OP_IMM: begin
                    fmt           = IMM_I;
                    dec.rhs_sel   = RHS_IMM;
                    dec.writes_rf = 1'b1;
                    dec.alu_op    = {2'b00, f3};
                    if (f3 == 3'b001) begin
                        legal = (f7 == 7'b0);
                    end else if (f3 == 3'b101) begin
                        // bit 30 selects SRAI and is not part of the legality check
                        dec.alu_op = {1'b0, instr[30], 3'b101};
                        legal      = !f7[6] && (f7[4:0] == 5'b0);
                    end
                end
                OPC_OP: begin
                    dec.writes_rf = 1'b1;
                    case (f7)
                        7'b0000000: dec.alu_op = {2'b00, f3};
                        7'b0100000: begin
                            dec.alu_op = {2'b01, f3};
                            legal      = (f3 == 3'b000) || (f3 == 3'b101);
                        end
                        7'b0000001: begin
                            dec.alu_op = {2'b10, f3};
                            legal      = ENABLE_M;
                        end
                        default: legal = 1'b0;
                    endcase
                end
                OPC_LOAD: begin
                    fmt           = IMM_I;
                    dec.rhs_sel   = RHS_IMM;
                    dec.reads_ram = 1'b1;
                    dec.writes_rf = 1'b1;
                    dec.mem_funct = f3;
                    legal         = (f3 != 3'b011) && (f3[2:1] != 2'b11);
                end
                OPC_STORE: begin
                    fmt            = IMM_S;
                    dec.rhs_sel    = RHS_IMM;
                    dec.writes_ram = 1'b1;
                    dec.mem_funct  = f3;
                    legal          = (f3 < 3'b011);
                end
                OPC_BRANCH: begin
                    fmt           = IMM_B;
                    dec.lhs_sel   = LHS_PC;
                    dec.rhs_sel   = RHS_IMM;
                    dec.branch    = 1'b1;
                    dec.mem_funct = f3;
                    legal         = (f3[2:1] != 2'b01);
                end
                OPC_JAL: begin
                    fmt           = IMM_J;
                    dec.lhs_sel   = LHS_PC;
                    dec.rhs_sel   = RHS_IMM;
                    dec.jump      = 1'b1;
                    dec.writes_rf = 1'b1;
                end
                OPC_JALR: begin
                    fmt           = IMM_I;
                    dec.rhs_sel   = RHS_IMM;
                    dec.jump      = 1'b1;
                    dec.writes_rf = 1'b1;
                    legal         = (f3 == 3'b000);
                end
                OPC_LUI: begin
                    fmt           = IMM_U;
                    dec.lhs_sel   = LHS_ZERO;
                    dec.rhs_sel   = RHS_IMM;
                    dec.writes_rf = 1'b1;
                end
                OPC_AUIPC: begin
                    fmt           = IMM_U;
                    dec.lhs_sel   = LHS_PC;
                    dec.rhs_sel   = RHS_IMM;
                    dec.writes_rf = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end

        dec.imm     = build_imm(fmt, instr);
        dec.illegal = !legal;
        if (!legal) begin
            dec.writes_rf  = 1'b0;
            dec.reads_ram  = 1'b0;
            dec.writes_ram = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered, handshaked RV32I decode stage with a one- or two-entry output
// buffer, flush, and a saturating illegal-instruction counter.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   Flush        : drop both buffered entries and the input offered this cycle
//   bus          : fetch handshake in, decoded entry + execute handshake out
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter bit ENABLE_M     = 1'b0,
    parameter int BUFFER_DEPTH = 2,
    parameter int ICOUNT_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Flush,
    rv32_decode_stage_if.slave bus
);

    if (BUFFER_DEPTH != 1 && BUFFER_DEPTH != 2) begin : g_bad_depth
        $error("rv32_decode_stage: BUFFER_DEPTH must be 1 or 2");
    end

    decoded_t            dec_in;
    decoded_t            main_q;
    decoded_t            skid_q;
    logic [31:0]         main_pc;
    logic [31:0]         skid_pc;
    logic                main_valid;
    logic                skid_valid;
    logic                in_ready;
    logic                take_in;
    logic [ICOUNT_W-1:0] icount;

    rv32_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
        .instr (bus.Instruction),
        .dec   (dec_in)
    );

    // Reset gating keeps InReady low for the whole reset pulse, not just
    // from the edge after it is first sampled.
    always_comb begin
        if (BUFFER_DEPTH == 1) begin
            in_ready = !Reset && (!main_valid || bus.OutReady);
        end else begin
            in_ready = !Reset && !skid_valid;
        end
    end

    assign take_in = bus.InValid && in_ready && !Flush;

    // Main register refills only when empty or consumed, so it holds steady
    // under backpressure; overflow lands in the skid register (depth 2 only,
    // since depth 1 never accepts while stalled).
    always_ff @(posedge Clock) begin
        if (Reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            main_pc    <= '0;
            skid_pc    <= '0;
            icount     <= '0;
        end else begin
            if (take_in && dec_in.illegal && (icount != '1)) begin
                icount <= icount + ICOUNT_W'(1);
            end
            if (Flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid || bus.OutReady) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    main_q     <= skid_q;
                    main_pc    <= skid_pc;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= take_in;
                    if (take_in) begin
                        main_q  <= dec_in;
                        main_pc <= bus.Pc;
                    end
                end
            end else if (take_in) begin
                skid_valid <= 1'b1;
                skid_q     <= dec_in;
                skid_pc    <= bus.Pc;
            end
        end
    end

    assign bus.InReady            = in_ready;
    assign bus.OutValid           = main_valid;
    assign bus.OutPc              = main_pc;
    assign bus.RD                 = main_q.rd;
    assign bus.RS1                = main_q.rs1;
    assign bus.RS2                = main_q.rs2;
    assign bus.Imm                = main_q.imm;
    assign bus.LhsSel             = main_q.lhs_sel;
    assign bus.RhsSel             = main_q.rhs_sel;
    assign bus.AluOp              = main_q.alu_op;
    assign bus.WritesRegisterFile = main_q.writes_rf;
    assign bus.ReadsRam           = main_q.reads_ram;
    assign bus.WritesRam          = main_q.writes_ram;
    assign bus.Branch             = main_q.branch;
    assign bus.Jump               = main_q.jump;
    assign bus.MemFunct           = main_q.mem_funct;
    assign bus.Illegal            = main_q.illegal;
    assign bus.IllegalCount       = icount;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench: DUT a = M enabled, skid buffer, 4-bit counter;
// DUT b = base only, single register, 16-bit counter.
module tb_rv32_decode_stage;

    logic clk;
    logic rst;
    logic flush_a;
    logic flush_b;
    int   n_cmp;
    int   n_bad;

    rv32_decode_stage_if #(.ICOUNT_W(4))  bus_a ();
    rv32_decode_stage_if #(.ICOUNT_W(16)) bus_b ();

    rv32_decode_stage #(.ENABLE_M(1'b1), .BUFFER_DEPTH(2), .ICOUNT_W(4)) u_a (
        .Clock (clk),
        .Reset (rst),
        .Flush (flush_a),
        .bus   (bus_a)
    );

    rv32_decode_stage #(.ENABLE_M(1'b0), .BUFFER_DEPTH(1), .ICOUNT_W(16)) u_b (
        .Clock (clk),
        .Reset (rst),
        .Flush (flush_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] ins, input logic [31:0] pc);
        bus_a.InValid     = 1'b1;
        bus_a.Instruction = ins;
        bus_a.Pc          = pc;
        tick();
        bus_a.InValid     = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] ins, input logic [31:0] pc);
        bus_b.InValid     = 1'b1;
        bus_b.Instruction = ins;
        bus_b.Pc          = pc;
        tick();
        bus_b.InValid     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        bus_a.InValid = 1'b0; bus_a.Instruction = '0; bus_a.Pc = '0; bus_a.OutReady = 1'b0;
        bus_b.InValid = 1'b0; bus_b.Instruction = '0; bus_b.Pc = '0; bus_b.OutReady = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk("a_rst_inready", bus_a.InReady, 0);
        chk("a_rst_outvalid", bus_a.OutValid, 0);
        chk("a_rst_icount", bus_a.IllegalCount, 0);
        chk("a_rst_imm", bus_a.Imm, 0);
        chk("a_rst_aluop", bus_a.AluOp, 0);
        chk("a_rst_outpc", bus_a.OutPc, 0);
        chk("b_rst_inready", bus_b.InReady, 0);
        chk("b_rst_outvalid", bus_b.OutValid, 0);
        rst = 1'b0;
        #1;
        chk("a_post_rst_inready", bus_a.InReady, 1);
        chk("b_post_rst_inready", bus_b.InReady, 1);

        // ---- decode, DUT a, OutReady high ----
        bus_a.OutReady = 1'b1;
        send_a(32'hFFF00093, 32'h100);              // ADDI x1,x0,-1
        chk("addi_valid", bus_a.OutValid, 1);
        chk("addi_rd", bus_a.RD, 1);
        chk("addi_imm", bus_a.Imm, 32'hFFFFFFFF);
        chk("addi_aluop", bus_a.AluOp, 5'b00000);
        chk("addi_rhs", bus_a.RhsSel, 1);
        chk("addi_wrf", bus_a.WritesRegisterFile, 1);
        chk("addi_pc", bus_a.OutPc, 32'h100);

        send_a(32'h40315113, 32'h104);              // SRAI x2,x2,3
        chk("srai_aluop", bus_a.AluOp, 5'b01101);
        chk("srai_imm", bus_a.Imm, 32'h00000403);
        chk("srai_ill", bus_a.Illegal, 0);

        send_a(32'h40208033, 32'h108);              // SUB
        chk("sub_aluop", bus_a.AluOp, 5'b01000);
        chk("sub_rhs", bus_a.RhsSel, 0);
        chk("sub_rs2", bus_a.RS2, 2);

        send_a(32'h02208033, 32'h10C);              // MUL with M enabled
        chk("mul_m_aluop", bus_a.AluOp, 5'b10000);
        chk("mul_m_ill", bus_a.Illegal, 0);

        send_a(32'hFE000EE3, 32'h110);              // BEQ -4
        chk("beq_imm", bus_a.Imm, 32'hFFFFFFFC);
        chk("beq_lhs", bus_a.LhsSel, 1);
        chk("beq_branch", bus_a.Branch, 1);
        chk("beq_memf", bus_a.MemFunct, 0);
        chk("beq_wrf", bus_a.WritesRegisterFile, 0);

        send_a(32'h123452B7, 32'h114);              // LUI x5,0x12345
        chk("lui_imm", bus_a.Imm, 32'h12345000);
        chk("lui_lhs", bus_a.LhsSel, 2);
        chk("lui_rd", bus_a.RD, 5);

        send_a(32'h00000000, 32'h118);              // all-zero word
        chk("zero_ill", bus_a.Illegal, 1);
        chk("zero_icount", bus_a.IllegalCount, 1);

        send_a(32'h40111093, 32'h11C);              // SLLI with funct7=0100000
        chk("slli_bad_ill", bus_a.Illegal, 1);
        chk("slli_bad_wrf", bus_a.WritesRegisterFile, 0);
        chk("slli_bad_icount", bus_a.IllegalCount, 2);

        tick();
        chk("drain_outvalid", bus_a.OutValid, 0);

        // ---- backpressure on the skid buffer ----
        bus_a.OutReady = 1'b0;
        send_a(32'h00100093, 32'h200);              // I1: addi imm 1
        chk("bp_inready_1", bus_a.InReady, 1);
        send_a(32'h00200093, 32'h204);              // I2 into skid
        chk("bp_inready_2", bus_a.InReady, 0);
        chk("bp_pc_hold1", bus_a.OutPc, 32'h200);
        bus_a.InValid = 1'b1; bus_a.Instruction = 32'h00300093; bus_a.Pc = 32'h208;
        tick();                                     // I3 offered, refused
        chk("bp_pc_hold2", bus_a.OutPc, 32'h200);
        chk("bp_imm_hold", bus_a.Imm, 1);
        chk("bp_inready_3", bus_a.InReady, 0);
        bus_a.OutReady = 1'b1;
        tick();                                     // skid -> main
        chk("bp_pc_i2", bus_a.OutPc, 32'h204);
        chk("bp_imm_i2", bus_a.Imm, 2);
        chk("bp_inready_4", bus_a.InReady, 1);
        tick();                                     // I3 accepted
        chk("bp_pc_i3", bus_a.OutPc, 32'h208);
        bus_a.Instruction = 32'h00400093; bus_a.Pc = 32'h20C;
        tick();
        chk("bp_pc_i4", bus_a.OutPc, 32'h20C);
        chk("bp_imm_i4", bus_a.Imm, 4);
        bus_a.InValid = 1'b0;
        tick();
        chk("bp_drain", bus_a.OutValid, 0);

        // ---- flush with both entries full ----
        bus_a.OutReady = 1'b0;
        send_a(32'h00500093, 32'h300);
        send_a(32'h00600093, 32'h304);
        chk("fl_full_inready", bus_a.InReady, 0);
        bus_a.InValid = 1'b1; bus_a.Instruction = 32'h00000000; bus_a.Pc = 32'h308;
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        bus_a.InValid = 1'b0;
        chk("fl_outvalid", bus_a.OutValid, 0);
        chk("fl_icount", bus_a.IllegalCount, 2);
        chk("fl_inready", bus_a.InReady, 1);
        bus_a.OutReady = 1'b1;
        tick();
        chk("fl_dropped", bus_a.OutValid, 0);

        // ---- counter saturation (4-bit) ----
        for (int k = 0; k < 18; k++) begin
            send_a(32'h00000000, 32'h400 + 32'(k));
            if (k == 11) chk("sat_mid", bus_a.IllegalCount, 14);
        end
        chk("sat_end", bus_a.IllegalCount, 15);

        // ---- reset mid-stream ----
        bus_a.OutReady = 1'b0;
        send_a(32'h00700093, 32'h500);
        chk("mr_valid_before", bus_a.OutValid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_outvalid", bus_a.OutValid, 0);
        chk("mr_icount", bus_a.IllegalCount, 0);
        chk("mr_imm", bus_a.Imm, 0);

        // ---- DUT b: no M, single register ----
        bus_b.OutReady = 1'b1;
        send_b(32'h02208033, 32'h600);              // MUL, M disabled
        chk("b_mul_ill", bus_b.Illegal, 1);
        chk("b_mul_wrf", bus_b.WritesRegisterFile, 0);
        chk("b_mul_icount", bus_b.IllegalCount, 1);

        send_b(32'h008000EF, 32'h604);              // JAL x1,+8
        chk("b_jal_imm", bus_b.Imm, 8);
        chk("b_jal_lhs", bus_b.LhsSel, 1);
        chk("b_jal_jump", bus_b.Jump, 1);
        chk("b_jal_pc", bus_b.OutPc, 32'h604);
        send_b(32'h000110E7, 32'h608);              // JALR funct3=001
        chk("b_jalr_ill", bus_b.Illegal, 1);
        chk("b_jalr_jump", bus_b.Jump, 0);
        chk("b_jalr_icount", bus_b.IllegalCount, 2);
        send_b(32'h00412183, 32'h60C);              // LW x3,4(x2)
        chk("b_lw_rdram", bus_b.ReadsRam, 1);
        chk("b_lw_memf", bus_b.MemFunct, 2);
        chk("b_lw_imm", bus_b.Imm, 4);
        chk("b_lw_rs1", bus_b.RS1, 2);

        bus_b.OutReady = 1'b0;
        #1;
        chk("b_stall_inready", bus_b.InReady, 0);
        bus_b.OutReady = 1'b1;
        #1;
        chk("b_comb_inready", bus_b.InReady, 1);
        tick();
        chk("b_drain", bus_b.OutValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
